// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with valid/ready handshakes and a
// two-entry (main + skid) output buffer that sustains one word per cycle.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    // Every immediate is first assembled as a 32-bit value whose bit 31 is
    // inst[31], so a single signed widening covers both XLEN choices.
    function automatic entry_t decode(input logic [31:0] inst);
        entry_t      e;
        logic [31:0] imm32;
        e       = '0;
        imm32   = 32'd0;
        e.fmt   = FMT_NONE;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                imm32 = {{20{inst[31]}}, inst[31:20]};
                e.fmt = FMT_I;
            end
            7'b0100011: begin
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                e.fmt = FMT_S;
            end
            7'b1100011: begin
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                e.fmt = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                imm32 = {inst[31:12], 12'b0};
                e.fmt = FMT_U;
            end
            7'b1101111: begin
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                e.fmt = FMT_J;
            end
            default: begin
                e.illegal = 1'b1;
            end
        endcase
        e.imm = XLEN'(signed'(imm32));
        return e;
    endfunction

    entry_t           m_q, m_d, k_q, k_d, dec_s;
    logic             m_valid_q, m_valid_d, k_valid_q, k_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept_s, xfer_s, m_free_s;

    assign accept_s = in_valid && in_ready_q && !flush;
    assign xfer_s   = m_valid_q && out_ready;
    assign m_free_s = !m_valid_q || xfer_s;

    // Next-state for the main/skid entries, the registered ready and the counter.
    always_comb begin
        dec_s     = decode(in_inst);
        m_d       = m_q;
        k_d       = k_q;
        m_valid_d = m_valid_q;
        k_valid_d = k_valid_q;
        cnt_d     = cnt_q;
        if (flush) begin
            m_valid_d = 1'b0;
            k_valid_d = 1'b0;
        end else begin
            if (k_valid_q) begin
                if (xfer_s) begin
                    m_d       = k_q;
                    m_valid_d = 1'b1;
                    if (accept_s) begin
                        k_d = dec_s;
                    end else begin
                        k_valid_d = 1'b0;
                    end
                end else begin
                    k_valid_d = 1'b1;
                end
            end else if (accept_s) begin
                if (m_free_s) begin
                    m_d       = dec_s;
                    m_valid_d = 1'b1;
                end else begin
                    k_d       = dec_s;
                    k_valid_d = 1'b1;
                end
            end else if (xfer_s) begin
                m_valid_d = 1'b0;
            end else begin
                m_valid_d = m_valid_q;
            end
            // Flushed words never reach this branch, so they are never counted.
            if (accept_s && dec_s.illegal && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end
        in_ready_d = !k_valid_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_q        <= '0;
            k_q        <= '0;
            m_valid_q  <= 1'b0;
            k_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            m_q        <= m_d;
            k_q        <= k_d;
            m_valid_q  <= m_valid_d;
            k_valid_q  <= k_valid_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = m_valid_q;
    assign out_imm     = m_q.imm;
    assign out_fmt     = m_q.fmt;
    assign out_illegal = m_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: two instances (XLEN=32/CNT_W=2 and XLEN=64/CNT_W=8) share
// stimulus; a monitor pops expected results produced by an arithmetic model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_inst;

    logic        ir0, ov0, il0;
    logic [31:0] imm0;
    logic [2:0]  f0;
    logic [1:0]  c0;
    logic        ir1, ov1, il1;
    logic [63:0] imm1;
    logic [2:0]  f1;
    logic [7:0]  c1;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .in_inst(in_inst), .out_valid(ov0), .out_ready(out_ready), .out_imm(imm0),
        .out_fmt(f0), .out_illegal(il0), .illegal_cnt(c0));

    imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_inst(in_inst), .out_valid(ov1), .out_ready(out_ready), .out_imm(imm1),
        .out_fmt(f1), .out_illegal(il1), .illegal_cnt(c1));

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t        sbq0[$];
    exp_t        sbq1[$];
    int          passed = 0;
    int          total  = 0;
    int          cntm[2];
    int          outs[2];
    bit          held[2];
    logic [63:0] h_imm[2];
    logic [2:0]  h_fmt[2];
    logic        h_ill[2];
    bit          started = 1'b0;
    bit          ovr_on  = 1'b0;
    logic [63:0] ovr_imm;
    logic [2:0]  ovr_fmt;
    int          rdy_mode = 1;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic fail_now(input string nm);
        total++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    // Reference: fields gathered with shifts and modulo, then made signed by subtraction.
    function automatic exp_t model(input logic [31:0] inst);
        exp_t   e;
        longint w, v;
        w = longint'({32'd0, inst});
        v = 64'sd0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        case (inst[6:0])
            7'h03, 7'h13, 7'h67: begin
                e.fmt = 3'd1;
                v = (w >> 20) % 4096;
                if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                e.fmt = 3'd2;
                v = ((w >> 25) % 128) * 32 + (w >> 7) % 32;
                if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                e.fmt = 3'd3;
                v = ((w >> 31) % 2) * 4096 + ((w >> 7) % 2) * 2048
                  + ((w >> 25) % 64) * 32 + ((w >> 8) % 16) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                v = (w >> 12) * 4096;
                if (v >= 64'sd2147483648) v -= 64'sd4294967296;
            end
            7'h6F: begin
                e.fmt = 3'd5;
                v = ((w >> 31) % 2) * 1048576 + ((w >> 12) % 256) * 4096
                  + ((w >> 20) % 2) * 2048 + ((w >> 21) % 1024) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            default: e.ill = 1'b1;
        endcase
        e.imm = v;
        return e;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? sbq0.size() : sbq1.size();
    endfunction

    task automatic mon(input int d, input logic ov, input logic ir, input logic [63:0] imm,
                       input logic [2:0] fmt, input logic ill, input logic [7:0] cnt);
        exp_t        e;
        logic [63:0] msk;
        int          cmax;
        msk  = (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        cmax = (d == 0) ? 3 : 255;
        check($sformatf("illegal_cnt[%0d]", d), {56'd0, cnt}, 64'(cntm[d]));
        if (reset) begin
            if (d == 0) sbq0.delete(); else sbq1.delete();
            cntm[d] = 0;
            held[d] = 1'b0;
        end else if (flush) begin
            if (d == 0) sbq0.delete(); else sbq1.delete();
            held[d] = 1'b0;
        end else begin
            if (ov === 1'b1) begin
                if (held[d]) begin
                    check($sformatf("stable_imm[%0d]", d), imm, h_imm[d]);
                    check($sformatf("stable_fmt[%0d]", d), {61'd0, fmt}, {61'd0, h_fmt[d]});
                end
                if (out_ready) begin
                    if (qsize(d) == 0) begin
                        fail_now($sformatf("unexpected_output[%0d]", d));
                    end else begin
                        e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
                        check($sformatf("imm[%0d]", d), imm & msk, e.imm & msk);
                        check($sformatf("fmt[%0d]", d), {61'd0, fmt}, {61'd0, e.fmt});
                        check($sformatf("illegal[%0d]", d), {63'd0, ill}, {63'd0, e.ill});
                        outs[d]++;
                    end
                    held[d] = 1'b0;
                end else begin
                    held[d]  = 1'b1;
                    h_imm[d] = imm;
                    h_fmt[d] = fmt;
                    h_ill[d] = ill;
                end
            end else begin
                held[d] = 1'b0;
            end
            if (in_valid && ir) begin
                if (ovr_on) begin
                    e.imm = ovr_imm;
                    e.fmt = ovr_fmt;
                    e.ill = (ovr_fmt == 3'd0);
                end else begin
                    e = model(in_inst);
                end
                if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
                if (e.ill && cntm[d] < cmax) cntm[d]++;
            end
        end
    endtask

    // Monitor: samples both instances on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            mon(0, ov0, ir0, {32'd0, imm0}, f0, il0, {6'd0, c0});
            mon(1, ov1, ir1, imm1, f1, il1, c1);
        end
    end

    // Downstream ready: held low, held high, or random per cycle.
    always @(posedge clk) begin
        #2;
        out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end

    task automatic send(input logic [31:0] inst, output int waited);
        bit acc;
        in_valid = 1'b1;
        in_inst  = inst;
        waited   = 0;
        forever begin
            @(negedge clk);
            acc = ir0;
            @(posedge clk);
            #1;
            waited++;
            if (acc) break;
            if (waited > 200) begin
                fail_now("accept_timeout");
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset_and_check();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid32", {63'd0, ov0}, 64'd0);
        check("rst_in_ready32", {63'd0, ir0}, 64'd1);
        check("rst_imm32", {32'd0, imm0}, 64'd0);
        check("rst_fmt32", {61'd0, f0}, 64'd0);
        check("rst_illegal32", {63'd0, il0}, 64'd0);
        check("rst_out_valid64", {63'd0, ov1}, 64'd0);
        check("rst_imm64", imm1, 64'd0);
        check("rst_cnt64", {56'd0, c1}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] kat_inst[5] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7, 32'h001000EF};
    logic [63:0] kat_imm[5]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC,
                                 64'hFFFF_FFFF_FFFF_FFF8, 64'h0000_0000_1234_5000,
                                 64'h0000_0000_0000_0800};
    logic [2:0]  kat_fmt[5]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [6:0]  ops[10]     = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00, 7'h33};
    logic [1:0]  cnt_seq[5]  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], ops[$urandom_range(0, 9)]};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w, tot, o;
        logic [1:0]  cb;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0; out_ready = 1'b1;
        cntm[0] = 0; cntm[1] = 0; outs[0] = 0; outs[1] = 0;
        held[0] = 1'b0; held[1] = 1'b0;
        @(posedge clk);
        #1;
        started = 1'b1;
        pulse_reset_and_check();

        // Known-answer decodes, each must appear one cycle after acceptance.
        for (int i = 0; i < 5; i++) begin
            ovr_on = 1'b1; ovr_imm = kat_imm[i]; ovr_fmt = kat_fmt[i];
            send(kat_inst[i], w);
            ovr_on = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            check("latency_valid", {63'd0, ov0}, 64'd1);
            @(posedge clk);
            #1;
        end

        // Backpressure: two words fill main+skid, third waits.
        rdy_mode = 0;
        send(32'hFFF00093, w);
        send(32'hFE112E23, w);
        in_valid = 1'b1;
        in_inst  = 32'hFE000CE3;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", {63'd0, ir0}, 64'd0);
            check("bp_hold_imm", {32'd0, imm0}, 64'h0000_0000_FFFF_FFFF);
            @(posedge clk);
            #1;
        end
        rdy_mode = 1;
        send(32'hFE000CE3, w);
        idle(4);
        check("bp_drain32", 64'(qsize(0)), 64'd0);
        check("bp_drain64", 64'(qsize(1)), 64'd0);

        // Full throughput.
        o = outs[0];
        tot = 0;
        for (int i = 0; i < 10; i++) begin
            send({$urandom_range(0, 32'h01FF_FFFF), 7'h13}, w);
            tot += w;
        end
        idle(2);
        check("tput_cycles", 64'(tot), 64'd10);
        check("tput_outputs", 64'(outs[0] - o), 64'd10);

        // Saturating counter on the CNT_W=2 instance.
        pulse_reset_and_check();
        for (int i = 0; i < 5; i++) begin
            ovr_on = 1'b1; ovr_imm = 64'd0; ovr_fmt = 3'd0;
            send(32'h0000_0000, w);
            ovr_on = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            check("sat_cnt", {62'd0, c0}, {62'd0, cnt_seq[i]});
            @(posedge clk);
            #1;
        end
        idle(2);

        // Flush with both entries full and an illegal word offered.
        rdy_mode = 0;
        send(32'h123452B7, w);
        send(32'h001000EF, w);
        cb = c0;
        in_valid = 1'b1; in_inst = 32'h0000_0000; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", {63'd0, ov0}, 64'd0);
        check("flush_in_ready", {63'd0, ir0}, 64'd1);
        check("flush_cnt", {62'd0, c0}, {62'd0, cb});
        @(posedge clk);
        #1;
        rdy_mode = 1;
        idle(2);

        // Random stream with random backpressure and a reset mid-way.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                in_valid = 1'b1;
                in_inst  = rand_inst();
                pulse_reset_and_check();
            end
            send(rand_inst(), w);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rdy_mode = 1;
        idle(6);
        check("final_drain32", 64'(qsize(0)), 64'd0);
        check("final_drain64", 64'(qsize(1)), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
